mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width on both sides.
REQ-002 Parameter LINE_W, default 128, refill/writeback line width in bits.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low clears all state immediately, independent of clock.
REQ-005 i_req / i_addr / i_ack / i_rdata  in/in/out/out  1/ADDR_W/1/LINE_W  instruction-cache refill port, read only.
REQ-006 d_req / d_we / d_addr / d_wdata / d_ack / d_rdata  in/in/in/in/out/out  1/1/ADDR_W/LINE_W/1/LINE_W  data-cache refill/writeback port.
REQ-007 mem_req / mem_we / mem_addr / mem_wdata  out/out/out/out  1/1/ADDR_W/LINE_W  shared main-memory request.
REQ-008 mem_ready / mem_rdata  in/in  1/LINE_W  main-memory completion strobe and read data.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 FSM states IDLE, BUSY, RESP; all outputs driven from registers.
REQ-011 IDLE: if any req high at clock edge, latch winner's id, addr, we (0 for I port), wdata into mem_* registers; go BUSY.
REQ-012 BUSY: mem_req held high, mem_* stable; on edge with mem_ready high capture mem_rdata, go RESP; mem_ready=0 -> stay BUSY, no timeout.
REQ-013 RESP: exactly one of i_ack/d_ack high for one cycle, matching latched id; corresponding *_rdata valid that cycle; go IDLE.
REQ-014 Minimum latency: req sampled edge N, mem_req high N+1, mem_ready at edge M, ack high M+1 cycle, IDLE M+2; single-cycle memory gives ack 3 cycles after req.
REQ-015 Requester holds req, addr, we, wdata stable until ack; drops req on edge ending RESP; arbiter never re-grants same request.
REQ-016 Both req high in IDLE: D port wins (fixed priority) unless REQ-023 applies.
REQ-017 Losing req remains pending; granted on next IDLE without loss.
REQ-018 mem_ready while IDLE or RESP ignored; req changes during BUSY/RESP ignored.
REQ-019 *_rdata hold last captured line outside RESP; write ack (d_we=1) returns mem_rdata as captured, content don't-care.
REQ-020 i_ack and d_ack never high simultaneously; mem_req low in IDLE and RESP.

Reset
REQ-021 reset low: state IDLE, mem_req/mem_we/i_ack/d_ack/busy = 0, mem_addr/mem_wdata/i_rdata/d_rdata = 0, round-robin pointer = I.
REQ-022 Reset mid-BUSY aborts transaction: mem_req drops asynchronously, no ack issued; requesters re-issue after reset.

Configuration
REQ-023 MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests go to port not granted last (pointer updated on each grant, initial favours I); undefined: fixed D priority per REQ-016, pointer logic absent.

Structure
REQ-024 Shared package mem_arb_pkg: state enum (IDLE, BUSY, RESP), requester id constants (REQ_I=0, REQ_D=1), default widths.
REQ-025 One sub-module arb_pick: combinational 2-way picker (requests, pointer, mode) -> grant id; instantiated once.

Verification
REQ-026 i_req=1, i_addr=0x0000_0040, memory ready after 1 cycle, rdata=0xA5..A5 -> mem_addr=0x40, mem_we=0, i_ack one cycle with i_rdata=0xA5..A5, 3 cycles after req.
REQ-027 d_req=1, d_we=1, d_addr=0x1000, d_wdata=0x1122..FF, memory ready after 5 cycles -> mem_we=1, mem_wdata matches, mem_req high 5 cycles, d_ack once.
REQ-028 i_req and d_req raised same edge, macro undefined -> D served first, then I; two acks, no overlap.
REQ-029 Same stimulus, MEM_ARB_ROUND_ROBIN_EN defined, repeated 4 times back-to-back -> grant order I, D, I, D, I, D, I, D.
REQ-030 reset low during BUSY (mem_ready held 0) -> mem_req, busy low without clock edge; no ack; after release, new i_req served normally.
REQ-031 mem_ready pulsed while IDLE with no req -> no state change, no ack, busy stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned LINE_W_DEF = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   // The port that should be favoured after the given port has been granted.
   function automatic logic other_port(input logic id);
      return ~id;
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational two-way picker: returns the id of the requester to grant.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic ptr,
   input  logic rr_mode,
   output logic grant_c
);

   // Contention resolves to the pointer in round-robin mode, otherwise to D.
   always_comb begin
      grant_c = REQ_I;
      if (i_req && d_req) begin
         grant_c = rr_mode ? ptr : REQ_D;
      end else if (d_req) begin
         grant_c = REQ_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache refills and D-cache refill/writeback onto one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on contention instead of fixed D priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [LINE_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              busy
);

   arb_state_t state_q, state_d;
   logic       start_c;
   logic       done_c;
   logic       grant_c;
   logic       id_q;
   logic       ptr_q;
   logic       rr_mode;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   assign rr_mode = 1'b1;

   // Pointer names the port to favour on the next contended grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= REQ_I;
      end else if (start_c) begin
         ptr_q <= other_port(grant_c);
      end
   end
`else
   assign rr_mode = 1'b0;
   assign ptr_q   = REQ_D;
`endif

   arb_pick u_pick (
      .i_req   (i_req),
      .d_req   (d_req),
      .ptr     (ptr_q),
      .rr_mode (rr_mode),
      .grant_c (grant_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      start_c = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               start_c = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               done_c  = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control outputs are registered copies of the next-state decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req <= 1'b0;
         busy    <= 1'b0;
         i_ack   <= 1'b0;
         d_ack   <= 1'b0;
      end else begin
         mem_req <= (state_d == BUSY);
         busy    <= (state_d != IDLE);
         i_ack   <= done_c && (id_q == REQ_I);
         d_ack   <= done_c && (id_q == REQ_D);
      end
   end

   // Request payload is latched at grant; returned line goes to the granted port only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q      <= REQ_I;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         if (start_c) begin
            id_q      <= grant_c;
            mem_we    <= (grant_c == REQ_D) && d_we;
            mem_addr  <= (grant_c == REQ_D) ? d_addr : i_addr;
            mem_wdata <= (grant_c == REQ_D) ? d_wdata : '0;
         end
         if (done_c) begin
            if (id_q == REQ_D) begin
               d_rdata <= mem_rdata;
            end else begin
               i_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized traffic against a timing model.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_req, d_req, d_we;
   logic [31:0]  i_addr, d_addr;
   logic [127:0] d_wdata;
   logic         i_ack, d_ack, mem_req, mem_we, mem_ready, busy;
   logic [127:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [31:0]  mem_addr;

   mem_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: one transaction in flight, timed by edges since grant.
   bit           tx_active = 1'b0;
   int           tx_age = 0;
   int           tx_lat = 0;
   logic         tx_id = 1'b0;
   logic [31:0]  tx_addr = '0;
   logic         tx_we = 1'b0;
   logic [127:0] tx_wdata = '0;
   logic [127:0] tx_line = '0;
   logic         rr_fav = 1'b0;
   logic [127:0] exp_i_rdata = '0;
   logic [127:0] exp_d_rdata = '0;
   int           next_lat = 1;
   logic [127:0] next_line = '0;
   int           mem_cnt = 0;
   int           mreq_ticks = 0;
   int           tick_no = 0;
   int           last_ack_tick = 0;
   int           i_ack_tick = -10;
   int           d_ack_tick = -10;
   logic         ack_log[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      logic si, sd, win;
      @(posedge clk);
      si = i_req;
      sd = d_req;
      if (!rst_n) begin
         tx_active = 1'b0;
      end else if (tx_active) begin
         tx_age++;
         if (tx_age > tx_lat) tx_active = 1'b0;
      end else if (si || sd) begin
         if (si && sd) win = RR ? rr_fav : 1'b1;
         else          win = sd;
         rr_fav    = ~win;
         tx_active = 1'b1;
         tx_age    = 0;
         tx_id     = win;
         tx_addr   = win ? d_addr : i_addr;
         tx_we     = win ? d_we : 1'b0;
         tx_wdata  = d_wdata;
         tx_lat    = next_lat;
         tx_line   = next_line;
      end
      #1;
      tick_no++;
      chk1("busy", busy, tx_active);
      chk1("mem_req", mem_req, tx_active && tx_age < tx_lat);
      chk1("i_ack", i_ack, tx_active && tx_age == tx_lat && tx_id == 1'b0);
      chk1("d_ack", d_ack, tx_active && tx_age == tx_lat && tx_id == 1'b1);
      if (tx_active && tx_age < tx_lat) begin
         chk("mem_addr", 128'(mem_addr), 128'(tx_addr));
         chk1("mem_we", mem_we, tx_we);
         if (tx_we) chk("mem_wdata", mem_wdata, tx_wdata);
      end
      if (tx_active && tx_age == tx_lat) begin
         if (tx_id) exp_d_rdata = tx_line;
         else       exp_i_rdata = tx_line;
      end
      chk("i_rdata", i_rdata, exp_i_rdata);
      chk("d_rdata", d_rdata, exp_d_rdata);
      if (i_ack) begin ack_log.push_back(1'b0); i_req = 1'b0; i_ack_tick = tick_no; last_ack_tick = tick_no; end
      if (d_ack) begin ack_log.push_back(1'b1); d_req = 1'b0; d_ack_tick = tick_no; last_ack_tick = tick_no; end
      if (mem_req) begin
         mreq_ticks++;
         mem_cnt++;
      end else begin
         mem_cnt = 0;
      end
      mem_ready = mem_req && (mem_cnt == tx_lat);
      mem_rdata = mem_ready ? tx_line : rnd_line();
   endtask

   task automatic run_idle(input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((i_req || d_req || tx_active) && n < budget);
      chk1("idle_timeout", i_req || d_req || tx_active, 1'b0);
   endtask

   initial begin
      int t0;
      logic exp_id;
      rst_n = 1'b0;
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      #1;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_i_ack", i_ack, 1'b0);
      chk1("rst_d_ack", d_ack, 1'b0);
      chk("rst_mem_addr", 128'(mem_addr), 128'(0));
      chk("rst_mem_wdata", mem_wdata, 128'(0));
      chk("rst_i_rdata", i_rdata, 128'(0));
      chk("rst_d_rdata", d_rdata, 128'(0));
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Single I refill, one-cycle memory
      next_lat = 1; next_line = {16{8'hA5}};
      i_addr = 32'h0000_0040; i_req = 1'b1;
      t0 = tick_no; mreq_ticks = 0; ack_log.delete();
      run_idle(20);
      chk("i_ack_cycle", 128'(last_ack_tick - t0 + 1), 128'(3));
      chk("i_ack_count", 128'(ack_log.size()), 128'(1));
      chk("i_mreq_cycles", 128'(mreq_ticks), 128'(1));
      chk("i_rdata_a5", i_rdata, {16{8'hA5}});

      // D writeback, five-cycle memory
      next_lat = 5; next_line = rnd_line();
      d_we = 1'b1; d_addr = 32'h0000_1000; d_wdata = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      d_req = 1'b1;
      mreq_ticks = 0; ack_log.delete();
      run_idle(30);
      chk("d_mreq_cycles", 128'(mreq_ticks), 128'(5));
      chk("d_ack_count", 128'(ack_log.size()), 128'(1));
      d_we = 1'b0;

      // Stray mem_ready pulse while idle
      tick();
      mem_ready = 1'b1; mem_rdata = rnd_line();
      tick();
      chk1("stray_busy", busy, 1'b0);
      tick();
      chk1("stray_busy2", busy, 1'b0);

      // Simultaneous requests, four rounds back-to-back
      ack_log.delete();
      for (int r = 0; r < 4; r++) begin
         next_lat = int'($urandom_range(1, 3)); next_line = rnd_line();
         i_addr = $urandom; d_addr = $urandom; d_we = 1'($urandom); d_wdata = rnd_line();
         i_req = 1'b1; d_req = 1'b1;
         run_idle(40);
      end
      chk("both_ack_count", 128'(ack_log.size()), 128'(8));
      for (int k = 0; k < 8 && k < ack_log.size(); k++) begin
         exp_id = RR ? (k % 2 == 1) : (k % 2 == 0);
         chk1("grant_order", ack_log[k], exp_id);
      end

      // Reset during BUSY with memory stalled
      next_lat = 1000; next_line = rnd_line();
      i_addr = 32'h0000_0080; i_req = 1'b1;
      ack_log.delete();
      tick(); tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk1("abort_mem_req", mem_req, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_i_ack", i_ack, 1'b0);
      tx_active = 1'b0; rr_fav = 1'b0;
      exp_i_rdata = '0; exp_d_rdata = '0;
      i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_cnt = 0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("abort_no_ack", 128'(ack_log.size()), 128'(0));
      next_lat = 2; next_line = rnd_line();
      i_addr = 32'h0000_0200; i_req = 1'b1;
      run_idle(20);
      chk("post_rst_acks", 128'(ack_log.size()), 128'(1));

      // Randomized traffic
      for (int it = 0; it < 300; it++) begin
         if (!i_req && tick_no > i_ack_tick && $urandom_range(0, 2) == 0) begin
            i_addr = $urandom; i_req = 1'b1;
         end
         if (!d_req && tick_no > d_ack_tick && $urandom_range(0, 2) == 0) begin
            d_addr = $urandom; d_we = 1'($urandom); d_wdata = rnd_line(); d_req = 1'b1;
         end
         next_lat  = int'($urandom_range(1, 4));
         next_line = rnd_line();
         tick();
      end
      run_idle(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
